reg_scoreboard: RTL
===================

# reg_scoreboard

Per-register pending-write scoreboard for the pipelined LEGv8 core. Decodes 5-bit destination register addresses from decode/issue (set side) and from the MEM/WB stage (clear side) into per-register outstanding-write counters. Answers two source-register busy queries per cycle so hazard logic can stall or forward. It is the write-address counterpart of the operand-select path that chooses which register addresses reach the register file read ports.

## Interface
Parameters:
- NREGS, 32, number of architectural registers tracked; index NREGS-1 is XZR.
- CNT_W, 2, width of each per-register outstanding-write counter; saturation value is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- issue_en  in  1  an instruction writing issue_rd leaves decode this cycle.
- issue_rd  in  5  destination register of the issuing instruction.
- wb_en  in  1  a register write commits in WB this cycle.
- wb_rd  in  5  destination register being written back.
- flush  in  1  pipeline flush; discard all outstanding writes.
- rs_a  in  5  source register A query address.
- rs_b  in  5  source register B query address.
- busy_a  out  1  rs_a has an outstanding write.
- busy_b  out  1  rs_b has an outstanding write.
- full  out  1  counter for issue_rd is saturated; issue must stall.
- pending  out  NREGS  bit i = counter i nonzero.
- any_pending  out  1  OR of pending.
- overflow  out  1  sticky: issue attempted while full.
- underflow  out  1  sticky: writeback to a register with zero count.

## Operation
- State: NREGS counters of CNT_W bits plus the two sticky flags. No other state.
- Decode: issue_rd and wb_rd are each decoded to a one-hot NREGS vector. Register 31 (XZR) is masked out of both vectors: it is never tracked, pending[31]=0, busy for address 31 is always 0, and no sticky flag is set for it.
- Per-register next count, in priority order:
  - flush=1: 0.
  - issue hit and wb hit on the same register: unchanged.
  - issue hit only: +1. If already saturated, count unchanged and overflow set.
  - wb hit only: -1. If already 0, count unchanged and underflow set.
  - neither: unchanged.
- Sticky flags are set on flush cycles too when their condition holds. They are cleared only by reset.
- full = (count[issue_rd] == max) and issue_rd != 31, combinational from registered state, independent of issue_en.
- busy_x = (count[rs_x] != 0), with the bypass adjustment under Configuration.
- Upstream must hold issue_en low while full. Behaviour on violation is defined (count preserved, overflow set) but is an error.

## Timing
- Reset: all counters 0; busy_a=busy_b=0, full=0, pending=0, any_pending=0, overflow=underflow=0, all immediately on assertion.
- Reset asserted mid-operation discards all counts in the same cycle; no partial update completes.
- Issue or writeback sampled at edge N is visible on pending, busy and full in the cycle after edge N (1-cycle latency).
- busy_*, full, pending and any_pending are combinational from registers plus current inputs. No combinational path from issue_en to any output.
- Flush takes effect at the edge: an issue in the flush cycle is dropped.

## Configuration
- WB_BYPASS_EN defined: busy_x is forced to 0 when wb_en=1, wb_rd==rs_x and count[rs_x]==1. The write-back being committed this cycle is visible to the reader, which matches a write-first register file. This adds a combinational path from wb_en/wb_rd to busy_*.
- WB_BYPASS_EN undefined: busy_x depends only on registered counts. A reader stalls one extra cycle behind the final write-back.

## Test plan
- Reset, then issue_rd=5 for one cycle -> pending[5]=1 next cycle. rs_a=5 gives busy_a=1 and rs_b=6 gives busy_b=0. Then wb_rd=5 -> pending[5]=0 the cycle after.
- Issue to register 9 three times (CNT_W=2) -> full=1 with issue_rd=9. A fourth issue -> count stays 3 and overflow=1. Three write-backs -> count 0 and overflow still 1.
- In the same cycle, issue_en and wb_en both target register 12, which holds count 1 -> count stays 1 and no flag changes.
- Issue_rd=31 and wb_rd=31 repeatedly -> pending=0, busy for rs=31 is 0, and overflow and underflow stay 0.
- Counts on registers 1, 2 and 3, then flush together with issue_rd=4 -> pending=0 and any_pending=0 next cycle. Then wb_rd=1 -> underflow=1.
- Count[7]=1, rs_a=7, wb_en=1 with wb_rd=7 -> with WB_BYPASS_EN busy_a=0 in the same cycle; without it busy_a=1 that cycle and 0 the next. Asserting reset mid-sequence clears every output immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: outstanding-write counters set at issue, cleared at WB.
// Define WB_BYPASS_EN to let a committing write-back clear busy_a/busy_b in the same cycle.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_en,
  input  logic [4:0]       issue_rd,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  input  logic [4:0]       rs_a,
  input  logic [4:0]       rs_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic             full,
  output logic [NREGS-1:0] pending,
  output logic             any_pending,
  output logic             overflow,
  output logic             underflow
);

  localparam int               XZR     = NREGS - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] issue_hit, wb_hit, sat, empty;
  logic [NREGS-1:0] inc, dec, ovf_hit, unf_hit;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_i;

  // XZR is masked out of both decoders so it can never accumulate a count or raise a flag.
  always_comb begin
    issue_hit = '0;
    wb_hit    = '0;
    sat       = '0;
    empty     = '0;
    for (int i = 0; i < NREGS; i++) begin
      issue_hit[i] = issue_en && (issue_rd == 5'(i)) && (i != XZR);
      wb_hit[i]    = wb_en && (wb_rd == 5'(i)) && (i != XZR);
      sat[i]       = (cnt[i] == CNT_MAX);
      empty[i]     = (cnt[i] == '0);
    end
  end

  assign inc     = issue_hit & ~wb_hit & ~sat;
  assign dec     = wb_hit & ~issue_hit & ~empty;
  assign ovf_hit = issue_hit & ~wb_hit & sat;
  assign unf_hit = wb_hit & ~issue_hit & empty;

  // NOTE: the counters are individual flops rather than a RAM, so clearing them all on reset is legal and cheap to reason about.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (flush)       cnt[i] <= '0;
        else if (inc[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      // Sticky flags still record errors that coincide with a flush.
      if (|ovf_hit) overflow  <= 1'b1;
      if (|unf_hit) underflow <= 1'b1;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_a = '0;
    cnt_b = '0;
    cnt_i = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rs_a == 5'(i))     cnt_a = cnt[i];
      if (rs_b == 5'(i))     cnt_b = cnt[i];
      if (issue_rd == 5'(i)) cnt_i = cnt[i];
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREGS; i++) pending[i] = (cnt[i] != '0);
  end

  assign any_pending = |pending;
  assign full        = (cnt_i == CNT_MAX) && (issue_rd != 5'(XZR));

`ifdef WB_BYPASS_EN
  // The last outstanding write committing this cycle is forwarded by a write-first register file.
  assign busy_a = (cnt_a != '0) && !(wb_en && (wb_rd == rs_a) && (cnt_a == CNT_W'(1)));
  assign busy_b = (cnt_b != '0) && !(wb_en && (wb_rd == rs_b) && (cnt_b == CNT_W'(1)));
`else
  assign busy_a = (cnt_a != '0);
  assign busy_b = (cnt_b != '0);
`endif

endmodule
